// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_pkg
// Description : Shared widths, the rest marker and player state encoding for
//               the note-ROM driven tone generator.
// Revision    : 1.0 - initial release
// ============================================================================
package tone_pkg;

    localparam int AW = 7;
    localparam int DW = 16;

    localparam logic [15:0] NOTE_REST = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        PLAY    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tone_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tone_prescaler
// Description : Free-running clk divider; tick is high for one cycle out of
//               every TICK_DIV while clear is low.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_prescaler #(
    parameter int TICK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    import tone_pkg::*;

    localparam int              c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    // With TICK_DIV == 1 the counter is pinned at 0 and tick is continuous.
    assign tick = !clear && (r_count == c_last);

    always_ff @(posedge clk) begin
        if (reset || clear || (r_count == c_last)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_tone_player.sv
`default_nettype none
// ============================================================================
// Module      : note_tone_player
// Description : Looks up a note's half-period divider in the external note ROM
//               and plays it as a square wave on the speaker output.
// Revision    : 1.0 - initial release
// ============================================================================
module note_tone_player #(
    parameter int TICK_DIV = 16,
    parameter int AW       = tone_pkg::AW,
    parameter int DW       = tone_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          note_valid,
    input  logic [AW-1:0] note_num,
    output logic          note_ready,
    input  logic          note_stop,
    output logic          rom_ce,
    output logic          rom_oce,
    output logic [AW-1:0] rom_ad,
    input  logic [DW-1:0] rom_dout,
    output logic          spk_out,
    output logic          playing,
    output logic [DW-1:0] cur_div
);
    import tone_pkg::*;

    state_t        r_state;
    logic          r_spk;
    logic          r_playing;
    logic          r_rom_ce;
    logic [AW-1:0] r_rom_ad;
    logic [DW-1:0] r_cur_div;
    logic [DW-1:0] r_half;

    logic          w_accept;
    logic          w_tick;
    logic          w_clear;
    logic          w_silent;

    // A stop request wins over a simultaneous note request.
    assign note_ready = ((r_state == IDLE) || (r_state == PLAY)) && !note_stop;
    assign w_accept   = note_valid && note_ready;
    assign w_clear    = (r_state != PLAY);
    assign w_silent   = (rom_dout == DW'(NOTE_REST)) || (rom_dout == '0);

    assign rom_ce  = r_rom_ce;
    assign rom_oce = 1'b1;
    assign rom_ad  = r_rom_ad;
    assign spk_out = r_spk;
    assign playing = r_playing;
    assign cur_div = r_cur_div;

    tone_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_spk     <= 1'b0;
            r_playing <= 1'b0;
            r_rom_ce  <= 1'b0;
            r_rom_ad  <= '0;
            r_cur_div <= '0;
            r_half    <= '0;
        end else if (note_stop) begin
            r_state   <= IDLE;
            r_spk     <= 1'b0;
            r_playing <= 1'b0;
            r_rom_ce  <= 1'b0;
        end else begin
            r_rom_ce <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rom_ad <= note_num;
                        r_rom_ce <= 1'b1;
                        r_state  <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_cur_div <= rom_dout;
                    if (w_silent) begin
                        r_state <= IDLE;
                    end else begin
                        r_state   <= PLAY;
                        r_half    <= rom_dout - 1'b1;
                        r_spk     <= 1'b0;
                        r_playing <= 1'b1;
                    end
                end
                PLAY: begin
                    if (w_accept) begin
                        // Retrigger restarts from a low output; no phase carry-over.
                        r_rom_ad  <= note_num;
                        r_rom_ce  <= 1'b1;
                        r_spk     <= 1'b0;
                        r_playing <= 1'b0;
                        r_state   <= FETCH;
                    end else if (w_tick) begin
                        if (r_half == '0) begin
                            r_spk  <= ~r_spk;
                            r_half <= r_cur_div - 1'b1;
                        end else begin
                            r_half <= r_half - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_tone_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_tone_player
// Description : Scoreboarded bench for note_tone_player with a note-ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_tone_player;

    localparam int TICK = 3;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        note_valid = 1'b0;
    logic [6:0]  note_num   = '0;
    logic        note_ready;
    logic        note_stop  = 1'b0;
    logic        rom_ce;
    logic        rom_oce;
    logic [6:0]  rom_ad;
    logic [15:0] rom_dout   = '0;
    logic        spk_out;
    logic        playing;
    logic [15:0] cur_div;

    int checks  = 0;
    int errors  = 0;
    int toggles = 0;
    logic [6:0] exp_ad[$];

    always #5 clk = ~clk;

    note_tone_player #(
        .TICK_DIV (TICK),
        .AW       (7),
        .DW       (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .note_valid (note_valid),
        .note_num   (note_num),
        .note_ready (note_ready),
        .note_stop  (note_stop),
        .rom_ce     (rom_ce),
        .rom_oce    (rom_oce),
        .rom_ad     (rom_ad),
        .rom_dout   (rom_dout),
        .spk_out    (spk_out),
        .playing    (playing),
        .cur_div    (cur_div)
    );

    function automatic logic [15:0] rom_val(input logic [6:0] n);
        int v;
        case (n)
            7'h00:   v = 32'hFFFF;
            7'h01:   v = 32'h168C;
            7'h05:   v = 0;
            7'h41:   v = 1;
            7'h70:   v = 9;
            7'h7E:   v = 32'hFFFE;
            7'h7F:   v = 4;
            default: v = (n >= 7'h40) ? 4 + (int'(n) * 5) % 17 : 32'h1000 + int'(n) * 64;
        endcase
        return 16'(v);
    endfunction

    function automatic bit is_rest(input logic [6:0] n);
        return (rom_val(n) == 16'hFFFF) || (rom_val(n) == 16'h0000);
    endfunction

    // Note ROM: registered read, data valid the cycle after the rom_ce edge.
    always @(posedge clk) begin
        if (rom_ce) rom_dout <= rom_val(rom_ad);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] n);
        int w = 0;
        while (!note_ready && w < 100) begin
            step(1);
            w++;
        end
        if (!note_ready) begin
            chk("ready_timeout", 32'(note_ready), 32'd1);
            return;
        end
        note_valid = 1'b1;
        note_num   = n;
        exp_ad.push_back(n);
        step(1);
        note_valid = 1'b0;
        note_num   = 7'($urandom);
    endtask

    // Monitor: pops the expected ROM address on every read strobe and times
    // every speaker edge against the model's half-period.
    task automatic monitor();
        logic       prev_ce  = 1'b0;
        logic       prev_spk = 1'b0;
        logic       tracking = 1'b0;
        logic       aborted  = 1'b1;
        logic [6:0] cur_note = '0;
        int         since    = 2;
        int         cnt      = 0;
        int         exp_half = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rom_ce) begin
                chk("rom_ce_single_cycle", 32'(prev_ce), 32'd0);
                chk("fetch_expected", 32'(exp_ad.size() > 0), 32'd1);
                if (exp_ad.size() > 0) begin
                    cur_note = exp_ad.pop_front();
                    chk("rom_ad", 32'(rom_ad), 32'(cur_note));
                end
                since    = 0;
                aborted  = reset || note_stop;
                tracking = 1'b0;
            end else if (since < 2) begin
                since++;
                if (since == 1) begin
                    aborted = aborted || reset || note_stop;
                end else if (!aborted) begin
                    chk("playing_after_capture", 32'(playing), 32'(!is_rest(cur_note)));
                    chk("cur_div", 32'(cur_div), 32'(rom_val(cur_note)));
                    if (!is_rest(cur_note)) begin
                        chk("spk_low_at_play_entry", 32'(spk_out), 32'd0);
                        tracking = 1'b1;
                        cnt      = 0;
                        exp_half = int'(rom_val(cur_note)) * TICK;
                        prev_spk = spk_out;
                    end
                end
            end else if (tracking) begin
                cnt++;
                chk("playing_held", 32'(playing), 32'd1);
                if (spk_out !== prev_spk) begin
                    chk("half_period", 32'(cnt), 32'(exp_half));
                    cnt      = 0;
                    prev_spk = spk_out;
                    toggles++;
                end else if (cnt > exp_half) begin
                    chk("half_period_overrun", 32'(cnt), 32'(exp_half));
                    tracking = 1'b0;
                end
            end
            // Inputs seen now act on the next edge: stop timing before an abort.
            if (tracking && (reset || note_stop || (note_valid && note_ready))) tracking = 1'b0;
            if (!playing) chk("spk_low_when_silent", 32'(spk_out), 32'd0);
            prev_ce = rom_ce;
        end
    endtask

    initial begin
        int t0;
        logic [6:0] n;

        step(3);
        reset = 1'b0;
        chk("reset_spk_out", 32'(spk_out), 32'd0);
        chk("reset_playing", 32'(playing), 32'd0);
        chk("reset_rom_ce", 32'(rom_ce), 32'd0);
        chk("reset_rom_ad", 32'(rom_ad), 32'd0);
        chk("reset_cur_div", 32'(cur_div), 32'd0);
        chk("reset_note_ready", 32'(note_ready), 32'd1);
        chk("rom_oce", 32'(rom_oce), 32'd1);

        fork
            monitor();
        join_none

        // Shortest production note, then count edges over six half-periods.
        send(7'h7F);
        chk("fetch_rom_ce", 32'(rom_ce), 32'd1);
        chk("fetch_rom_ad", 32'(rom_ad), 32'h7F);
        chk("fetch_note_ready", 32'(note_ready), 32'd0);
        step(2);
        chk("play_playing", 32'(playing), 32'd1);
        chk("play_cur_div", 32'(cur_div), 32'h0004);
        chk("play_note_ready", 32'(note_ready), 32'd1);
        t0 = toggles;
        step(4 * TICK * 6 + 1);
        chk("toggles_7f", 32'(toggles - t0), 32'd6);

        // Rest markers: 0xFFFF and 0x0000 both fall back to idle.
        send(7'h00);
        step(2);
        chk("rest_playing", 32'(playing), 32'd0);
        chk("rest_spk_out", 32'(spk_out), 32'd0);
        chk("rest_note_ready", 32'(note_ready), 32'd1);
        chk("rest_cur_div", 32'(cur_div), 32'hFFFF);
        send(7'h05);
        step(2);
        chk("zero_div_playing", 32'(playing), 32'd0);
        chk("zero_div_cur_div", 32'(cur_div), 32'd0);

        t0 = toggles;
        send(7'h70);
        step(2 + 9 * TICK * 10 + 5);
        chk("toggles_70", 32'(toggles - t0), 32'd10);

        // Retrigger from PLAY into the long note 0x01.
        send(7'h7F);
        step(40);
        send(7'h01);
        chk("retrig_spk_out", 32'(spk_out), 32'd0);
        chk("retrig_playing", 32'(playing), 32'd0);
        chk("retrig_rom_ce", 32'(rom_ce), 32'd1);
        chk("retrig_rom_ad", 32'(rom_ad), 32'h01);
        t0 = toggles;
        step(2 + 2 * 16'h168C * TICK + 8);
        chk("toggles_01", 32'(toggles - t0), 32'd2);

        // Stop and a new note in the same cycle: stop wins, note dropped.
        note_stop  = 1'b1;
        note_valid = 1'b1;
        note_num   = 7'h7F;
        #1;
        chk("stop_blocks_ready", 32'(note_ready), 32'd0);
        step(1);
        note_stop  = 1'b0;
        note_valid = 1'b0;
        chk("stop_playing", 32'(playing), 32'd0);
        chk("stop_spk_out", 32'(spk_out), 32'd0);
        chk("stop_cur_div_kept", 32'(cur_div), 32'h168C);
        step(1);
        chk("stop_no_rom_ce", 32'(rom_ce), 32'd0);
        chk("stop_note_ready", 32'(note_ready), 32'd1);

        // Longest legal divider.
        send(7'h7E);
        step(2);
        chk("fffe_playing", 32'(playing), 32'd1);
        chk("fffe_cur_div", 32'(cur_div), 32'hFFFE);
        step(50);
        chk("fffe_spk_out", 32'(spk_out), 32'd0);
        note_stop = 1'b1;
        step(1);
        note_stop = 1'b0;

        // Reset while the fetch is outstanding.
        send(7'h7F);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_fetch_spk_out", 32'(spk_out), 32'd0);
        chk("rst_fetch_playing", 32'(playing), 32'd0);
        chk("rst_fetch_rom_ce", 32'(rom_ce), 32'd0);
        chk("rst_fetch_rom_ad", 32'(rom_ad), 32'd0);
        chk("rst_fetch_cur_div", 32'(cur_div), 32'd0);
        chk("rst_fetch_note_ready", 32'(note_ready), 32'd1);
        step(3);
        chk("rst_fetch_no_capture", 32'(playing), 32'd0);
        chk("rst_fetch_cur_div_hold", 32'(cur_div), 32'd0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       n = 7'h00;
                1:       n = 7'h05;
                2:       n = 7'h41;
                default: n = 7'($urandom_range(7'h40, 7'h7D));
            endcase
            send(n);
            step($urandom_range(0, 80));
            if ($urandom_range(0, 4) == 0) begin
                note_stop = 1'b1;
                step(1);
                note_stop = 1'b0;
            end
        end

        step(100);
        note_stop = 1'b1;
        step(1);
        note_stop = 1'b0;
        step(3);
        chk("fetch_queue_empty", 32'(exp_ad.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_tone_player.md
Name: note_tone_player

Overview:
- Consumer side of the 128-entry note ROM (16-bit half-period divider per MIDI-style note number, 0xFFFF = rest).
- Accepts a note number through a valid/ready handshake, then drives the ROM read port (ce/oce/ad).
- Captures the divider one cycle after the read and generates a square-wave speaker output whose half-period is that many prescaled ticks.
- Sits between the sequencer/melody logic and the speaker pin.

Parameters:
- TICK_DIV, 16, clk cycles per divider tick (prescaler); 1 = tick every clk.
- AW, 7, note number / ROM address width.
- DW, 16, ROM data / divider width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- note_valid  in  1  new note request
- note_num  in  AW  note number (ROM address)
- note_ready  out  1  handshake ready; transfer when note_valid & note_ready
- note_stop  in  1  stop playback, return to idle
- rom_ce  out  1  ROM clock enable (read strobe)
- rom_oce  out  1  ROM output clock enable (held 1)
- rom_ad  out  AW  ROM address
- rom_dout  in  DW  ROM data, valid the cycle after the rom_ce edge (bypass read mode)
- spk_out  out  1  square-wave speaker output
- playing  out  1  high while a non-silent tone is being generated
- cur_div  out  DW  latched divider of current note (debug)

Behaviour:
- Reset: state=IDLE, spk_out=0, playing=0, rom_ce=0, rom_ad=0, cur_div=0, prescaler=0, half counter=0, note_ready=1 on the cycle after reset deasserts. rom_oce=1 always.
- Mid-operation reset overrides everything, including a pending fetch.
- States: IDLE, FETCH, CAPTURE, PLAY.
- IDLE: note_ready=1; spk_out=0. On accept -> FETCH, register rom_ad=note_num.
- FETCH (1 cycle): rom_ce=1, note_ready=0 -> CAPTURE.
- CAPTURE (1 cycle): rom_ce=0; cur_div<=rom_dout.
  - If rom_dout==16'hFFFF or 0 -> IDLE (rest; playing=0).
  - Otherwise -> PLAY; half counter<=rom_dout-1, prescaler<=0, spk_out<=0.
- PLAY: playing=1, note_ready=1.
  - Prescaler counts 0..TICK_DIV-1; tick when prescaler==TICK_DIV-1.
  - On tick: if half counter==0, toggle spk_out and reload cur_div-1; else decrement.
  - Half-period = cur_div*TICK_DIV clk cycles exactly.
- Latency: accept at edge T -> FETCH T+1 -> CAPTURE T+2 -> PLAY from T+3. First toggle occurs cur_div*TICK_DIV cycles after PLAY entry.
- New note accepted in PLAY: spk_out<=0, playing<=0, -> FETCH (retrigger; no phase continuity).
- note_stop: in any state -> IDLE next cycle, spk_out=0, playing=0; it has priority over a simultaneous note_valid, which is not accepted (note_ready is forced 0 while note_stop=1).
- note_num is only sampled on the accept cycle; later changes are ignored.
- Counters never wrap: the reload happens at 0. Divider 0xFFFE is legal (longest tone).

Decomposition:
- Shared package (tone_pkg): AW, DW, NOTE_REST=16'hFFFF, state enum {IDLE, FETCH, CAPTURE, PLAY}.
- One natural sub-module: tone_prescaler (parameter TICK_DIV, inputs clk/reset/clear, output tick), reusable by other audio blocks.
- Top instantiates it alongside the notes ROM at system level, not inside this block.

Test Plan:
- Bench ROM model with the production table, TICK_DIV=1.
- Play note 0x7F (div 0x0004) -> rom_ce pulses 1 cycle with rom_ad=0x7F; PLAY at T+3; spk_out toggles every 4 clk; playing=1; cur_div=0x0004.
- Note 0x00 (0xFFFF) -> returns to IDLE at T+3; spk_out stays 0; playing=0; note_ready=1.
- Note 0x70 (div 0x0009) with TICK_DIV=3 -> spk_out half-period 27 clk, measured over 10 toggles.
- Playing 0x7F, send 0x01 (div 0x168C) -> spk_out forced 0, second rom_ce with rom_ad=0x01, then half-period 5772 clk.
- note_stop and note_valid asserted together during PLAY -> IDLE next cycle; note not accepted; spk_out=0; no rom_ce pulse.
- Reset asserted in FETCH state -> next cycle all outputs at reset values; no CAPTURE; cur_div=0.
